// File: rtl/nn_pkg.sv
// Shared types for the NN memory subsystem: address/data widths, lane count
// and the arbiter state encoding.
package nn_pkg;

  localparam int LANES = 8;

  typedef logic [16:0] Caddr;
  typedef logic [31:0] Cdata;
  typedef logic [16:0] Maddr;
  typedef logic [23:0] Mdata;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FP   = 2'd1,
    ST_WB   = 2'd2
  } arb_st_e;

  typedef enum logic {
    WIN_WB = 1'b0,
    WIN_FP = 1'b1
  } win_e;

endpackage

// File: rtl/nn_rd_hold.sv
// Read-data hold for one memory: forwards the macro output in the cycle after a
// fetch grant and keeps that value visible until the next grant's data arrives.
module nn_rd_hold #(
  parameter int LANES = 8,
  parameter int W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      grant,
  input  logic [LANES-1:0][W-1:0]   q,
  output logic [LANES-1:0][W-1:0]   data
);

  logic                     fp_pend;
  logic [LANES-1:0][W-1:0]  hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      fp_pend <= 1'b0;
      hold    <= '0;
    end else begin
      fp_pend <= grant;
      if (fp_pend) hold <= q;
    end
  end

  assign data = fp_pend ? q : hold;

endmodule

// File: rtl/nn_mem_arbiter.sv
// Arbiter for the shared cmem/dmem ports between the fetch/populate sequencer
// (8-lane reads) and neuron write-back (single-word dmem writes).
//
// state   | meaning
// IDLE    | no grant this cycle
// FP      | fetch read granted this cycle
// WB      | write-back granted this cycle
module nn_mem_arbiter
  import nn_pkg::*;
#(
  parameter int MAX_FP_BURST = 4,
  parameter int LANES        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_rqt_fp,
  input  Caddr [LANES-1:0]      cmem_addr_fp,
  input  Maddr [LANES-1:0]      dmem_addr_fp,
  output logic                  grant_fp,
  output Cdata [LANES-1:0]      cmem_data_fp,
  output Mdata [LANES-1:0]      dmem_data_fp,
  input  logic                  wb_valid,
  input  Maddr                  wb_addr,
  input  Mdata                  wb_data,
  output logic                  wb_ready,
  output logic                  cmem_rd_en,
  output Caddr [LANES-1:0]      cmem_addr,
  input  Cdata [LANES-1:0]      cmem_q,
  output logic                  dmem_rd_en,
  output logic                  dmem_wr_en,
  output Maddr [LANES-1:0]      dmem_addr,
  output Mdata                  dmem_wdata,
  input  Mdata [LANES-1:0]      dmem_q
);

  localparam logic [2:0] BURST_MAX = 3'(MAX_FP_BURST);

  arb_st_e    state;
  win_e       last_winner;
  logic [2:0] burst_cnt;
  logic       fp_keeps;

  // A running fp burst (burst_cnt != 0) may continue until it saturates; a fresh
  // contention goes to whichever side did not win last.
  assign fp_keeps = (burst_cnt < BURST_MAX) &&
                    ((last_winner == WIN_WB) || (burst_cnt != 3'd0));

  always_comb begin
    state = ST_IDLE;
    if (!reset) begin
      if (memory_rqt_fp && wb_valid) state = fp_keeps ? ST_FP : ST_WB;
      else if (memory_rqt_fp)        state = ST_FP;
      else if (wb_valid)             state = ST_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt   <= 3'd0;
      last_winner <= WIN_WB;
    end else begin
      if (state == ST_WB || !wb_valid)             burst_cnt <= 3'd0;
      else if (state == ST_FP && burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 3'd1;

      if (state == ST_FP)      last_winner <= WIN_FP;
      else if (state == ST_WB) last_winner <= WIN_WB;
    end
  end

  assign grant_fp   = (state == ST_FP);
  assign wb_ready   = (state == ST_WB);
  assign cmem_rd_en = grant_fp;
  assign dmem_rd_en = grant_fp;
  assign dmem_wr_en = wb_ready;
  assign dmem_wdata = wb_ready ? wb_data : '0;
  assign cmem_addr  = grant_fp ? cmem_addr_fp : '0;

  always_comb begin
    dmem_addr = '0;
    if (grant_fp)      dmem_addr = dmem_addr_fp;
    else if (wb_ready) dmem_addr[0] = wb_addr;
  end

  nn_rd_hold #(.LANES(LANES), .W(32)) u_cmem_hold (
    .clk   (clk),
    .reset (reset),
    .grant (grant_fp),
    .q     (cmem_q),
    .data  (cmem_data_fp)
  );

  nn_rd_hold #(.LANES(LANES), .W(24)) u_dmem_hold (
    .clk   (clk),
    .reset (reset),
    .grant (grant_fp),
    .q     (dmem_q),
    .data  (dmem_data_fp)
  );

endmodule

// File: tb/tb_nn_mem_arbiter.sv
// Directed bench for nn_mem_arbiter with a simple memory-macro model whose
// output turns to noise on non-read cycles.
module tb_nn_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic memory_rqt_fp;
  logic [7:0][16:0] cmem_addr_fp;
  logic [7:0][16:0] dmem_addr_fp;
  logic grant_fp;
  logic [7:0][31:0] cmem_data_fp;
  logic [7:0][23:0] dmem_data_fp;
  logic wb_valid;
  logic [16:0] wb_addr;
  logic [23:0] wb_data;
  logic wb_ready;
  logic cmem_rd_en;
  logic [7:0][16:0] cmem_addr;
  logic [7:0][31:0] cmem_q;
  logic dmem_rd_en;
  logic dmem_wr_en;
  logic [7:0][16:0] dmem_addr;
  logic [23:0] dmem_wdata;
  logic [7:0][23:0] dmem_q;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nn_mem_arbiter #(.MAX_FP_BURST(4), .LANES(8)) dut (
    .clk(clk), .reset(reset),
    .memory_rqt_fp(memory_rqt_fp), .cmem_addr_fp(cmem_addr_fp), .dmem_addr_fp(dmem_addr_fp),
    .grant_fp(grant_fp), .cmem_data_fp(cmem_data_fp), .dmem_data_fp(dmem_data_fp),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .cmem_rd_en(cmem_rd_en), .cmem_addr(cmem_addr), .cmem_q(cmem_q),
    .dmem_rd_en(dmem_rd_en), .dmem_wr_en(dmem_wr_en), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_q(dmem_q)
  );

  function automatic logic [31:0] cval(input logic [16:0] a);
    return 32'hDEAD_BEEF ^ {15'd0, a};
  endfunction

  function automatic logic [23:0] dval(input logic [16:0] a);
    return 24'hA5_0000 ^ {7'd0, a};
  endfunction

  // Macro model: one-cycle read latency, garbage output otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      cmem_q[i] <= cmem_rd_en ? cval(cmem_addr[i]) : $urandom;
      dmem_q[i] <= dmem_rd_en ? dval(dmem_addr[i]) : 24'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; caller then sets inputs and settles.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nxt();
    reset = 1'b1; memory_rqt_fp = 1'b0; wb_valid = 1'b0;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  string exp_seq = "FFFFWFFFFW";
  int gcount;

  initial begin
    reset = 1'b1; memory_rqt_fp = 1'b0; wb_valid = 1'b0;
    wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 8; i++) begin
      cmem_addr_fp[i] = 17'(i);
      dmem_addr_fp[i] = 17'(100 + i);
    end
    do_reset();

    // reset state
    #3;
    chk("rst_grant_fp", 64'(grant_fp), 64'd0);
    chk("rst_wb_ready", 64'(wb_ready), 64'd0);
    chk("rst_cmem_rd_en", 64'(cmem_rd_en), 64'd0);
    chk("rst_cmem_data0", 64'(cmem_data_fp[0]), 64'd0);
    chk("rst_dmem_data5", 64'(dmem_data_fp[5]), 64'd0);

    // single fetch, then hold across idle cycles
    nxt();
    memory_rqt_fp = 1'b1;
    #3;
    chk("t1_grant", 64'(grant_fp), 64'd1);
    chk("t1_rd_en", 64'({cmem_rd_en, dmem_rd_en}), 64'd3);
    chk("t1_cmem_addr3", 64'(cmem_addr[3]), 64'd3);
    chk("t1_dmem_addr7", 64'(dmem_addr[7]), 64'd107);
    nxt();
    memory_rqt_fp = 1'b0;
    #3;
    chk("t1_grant_drop", 64'(grant_fp), 64'd0);
    chk("t1_cdata0", 64'(cmem_data_fp[0]), 64'hDEADBEEF);
    chk("t1_ddata2", 64'(dmem_data_fp[2]), 64'(24'hA50000 ^ 24'd102));
    chk("t1_idle_addr", 64'(cmem_addr[3]), 64'd0);
    for (int k = 0; k < 5; k++) nxt();
    #3;
    chk("t1_hold_cdata0", 64'(cmem_data_fp[0]), 64'hDEADBEEF);
    chk("t1_hold_ddata2", 64'(dmem_data_fp[2]), 64'(24'hA50000 ^ 24'd102));

    // contention from reset: 4 fp grants then one wb, repeating
    do_reset();
    wb_addr = 17'h00ABC; wb_data = 24'h123456;
    for (int c = 0; c < 10; c++) begin
      memory_rqt_fp = 1'b1; wb_valid = 1'b1;
      #3;
      chk($sformatf("t2_grant_fp_c%0d", c), 64'(grant_fp), 64'(exp_seq[c] == "F"));
      chk($sformatf("t2_wb_ready_c%0d", c), 64'(wb_ready), 64'(exp_seq[c] == "W"));
      if (c == 4) begin
        chk("t2_wr_en", 64'(dmem_wr_en), 64'd1);
        chk("t2_wr_addr", 64'(dmem_addr[0]), 64'h00ABC);
        chk("t2_wr_data", 64'(dmem_wdata), 64'h123456);
        chk("t2_wr_cmem_idle", 64'(cmem_rd_en), 64'd0);
        chk("t2_data_after_fp", 64'(cmem_data_fp[1]), 64'(32'hDEADBEEF ^ 32'd1));
      end
      nxt();
    end

    // wb only, consecutive writes
    memory_rqt_fp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wb_valid = 1'b1; wb_addr = 17'(16 + c); wb_data = 24'(c + 7);
      #3;
      chk($sformatf("t3_wb_ready_%0d", c), 64'(wb_ready), 64'd1);
      chk($sformatf("t3_addr_%0d", c), 64'(dmem_addr[0]), 64'(16 + c));
      chk($sformatf("t3_wdata_%0d", c), 64'(dmem_wdata), 64'(c + 7));
      chk($sformatf("t3_cmem_rd_%0d", c), 64'(cmem_rd_en), 64'd0);
      nxt();
    end
    wb_valid = 1'b0;
    #3;
    chk("t3_hold_cdata1", 64'(cmem_data_fp[1]), 64'(32'hDEADBEEF ^ 32'd1));

    // reset right after an fp grant discards the read
    nxt();
    memory_rqt_fp = 1'b1;
    #3;
    chk("t4_grant", 64'(grant_fp), 64'd1);
    nxt();
    memory_rqt_fp = 1'b0; reset = 1'b1;
    #3;
    chk("t4_grant_in_rst", 64'(grant_fp), 64'd0);
    nxt();
    reset = 1'b0;
    #3;
    chk("t4_ddata0_zero", 64'(dmem_data_fp[0]), 64'd0);
    chk("t4_cdata4_zero", 64'(cmem_data_fp[4]), 64'd0);
    chk("t4_no_grant", 64'({grant_fp, wb_ready}), 64'd0);

    // fp-only grant leaves last_winner = FP with burst cleared
    nxt();
    for (int i = 0; i < 8; i++) cmem_addr_fp[i] = 17'(40 + i);
    memory_rqt_fp = 1'b1;
    #3;
    chk("t5_pre_grant", 64'(grant_fp), 64'd1);
    nxt();
    memory_rqt_fp = 1'b0;
    nxt();
    // fp held while wb takes the first slot
    for (int i = 0; i < 8; i++) cmem_addr_fp[i] = 17'(60 + i);
    gcount = 0;
    memory_rqt_fp = 1'b1; wb_valid = 1'b1; wb_addr = 17'h1F; wb_data = 24'hBEEF01;
    #3;
    chk("t5_wb_first", 64'(wb_ready), 64'd1);
    chk("t5_fp_wait", 64'(grant_fp), 64'd0);
    gcount += int'(grant_fp);
    nxt();
    wb_valid = 1'b0;
    #3;
    chk("t5_fp_granted", 64'(grant_fp), 64'd1);
    chk("t5_addr_stable", 64'(cmem_addr[2]), 64'd62);
    gcount += int'(grant_fp);
    nxt();
    memory_rqt_fp = 1'b0;
    #3;
    gcount += int'(grant_fp);
    chk("t5_grant_once", 64'(gcount), 64'd1);
    chk("t5_rdata", 64'(cmem_data_fp[2]), 64'(32'hDEADBEEF ^ 32'd62));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
